pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
- Parametrised, pipelined successor to the fixed 4-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple segments, with the carry registered between segments.
- Sustains one operation per clock with valid/ready flow control.
- Used wherever wide adds must close timing; sits between operand registers and downstream ALU/accumulator logic.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline segments; SEG = WIDTH/STAGES bits per segment; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- flush  input  1  synchronous clear of all in-flight operations.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: {cout,sum} = a + ~b + ~cin, i.e. a − b − cin.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0), computed in the final stage.
- Pipeline:
  - Stage k (0..STAGES-1) adds segment bits [k*SEG +: SEG] using the registered carry from stage k-1; stage 0 uses the effective cin.
  - Upper operand segments are carried forward in skew registers.
  - Lower result segments are carried forward in de-skew registers.
  - All segments of one operation emerge aligned.
- Latency: exactly STAGES cycles from the accepting edge (in_valid && in_ready) to out_valid, when out_ready is held high.
- Throughput: one operation per cycle; no bubbles while out_ready=1.
- Handshake:
  - in_ready = !out_valid || out_ready (global stall).
  - When stalled (out_valid && !out_ready), every stage register, valid bit and output holds.
  - Inputs are ignored when in_ready=0.
  - Output is consumed on the edge where out_valid && out_ready.
  - Bubbles (in_valid=0 on an accepting edge) propagate as invalid slots.
  - Bubbles are compressed only at the output: a stage whose valid is 0 may be overwritten even during a stall only if an implementation chooses per-stage stalling. Required minimum is global stall; out_valid ordering must be strictly FIFO.
- Reset: rst_n low asynchronously clears all valid bits, out_valid, sum, cout, ovf and zero to 0. in_ready reads 1 during and after reset. The first accept is possible on the first edge after rst_n rises.
- Flush: on an edge with flush=1, all valid bits clear; the input presented that cycle is dropped. out_valid=0 the next cycle. Flush overrides stall and accept.
- Output registers: sum, cout, ovf and zero are registered and stable while out_valid=1 and out_ready=0.
- Boundary cases:
  - Full carry ripple across all segments (e.g. 0xFFFF+1) must produce the correct result.
  - Simultaneous accept and output consume in the same cycle is legal.
  - STAGES=1 degenerates to a single registered adder with latency 1.

Test Plan:
1. Reset, then a=0x1234, b=0x4321, cin=0, sub=0, single accept, out_ready=1 -> after 4 cycles out_valid=1, sum=0x5555, cout=0, ovf=0, zero=0.
2. a=0xFFFF, b=0x0000, cin=1, sub=0 (carry through every segment) -> sum=0x0000, cout=1, zero=1, ovf=0; then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
3. sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0; then a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
4. Back-to-back stream of 20 random operations with out_ready random (~50%) -> in-order results matching the reference model; no loss or duplication; outputs stable during stalls; in_ready=0 exactly when out_valid && !out_ready.
5. Three ops in flight, assert flush for one cycle (with in_valid=1) -> none of the four emerge; next accepted op emerges after 4 cycles with the correct result.
6. Assert rst_n low asynchronously mid-stream (between edges) -> out_valid and outputs go to 0 immediately; nothing in flight emerges after release. Repeat scenario 2 with STAGES=1 and WIDTH=8 -> latency 1 and correct results.

Source files
------------

// File: rtl/pipelined_rca.sv
// Parametrised pipelined ripple-carry add/subtract. WIDTH bits are split into
// STAGES segments with the inter-segment carry registered; global stall flow control.
module pipelined_rca #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG = WIDTH / STAGES;

  // Per-stage registers: a_q/b_q skew the not-yet-added operand segments
  // forward, r_q de-skews the already-computed result segments.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;
  logic              zero_q;

  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  r_n [STAGES];
  logic [SEG:0]      seg_sum [STAGES];
  logic [STAGES-1:0] c_n;
  logic              ovf_n;
  logic              zero_n;
  logic              advance;

  assign advance   = !v_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    // Subtract is a + ~b with the borrow-in inverted into the carry-in.
    a_n[0]     = a;
    b_n[0]     = sub ? ~b : b;
    seg_sum[0] = {1'b0, a_n[0][SEG-1:0]} + {1'b0, b_n[0][SEG-1:0]}
               + {{SEG{1'b0}}, sub ^ cin};
    r_n[0]     = '0;
    r_n[0][SEG-1:0] = seg_sum[0][SEG-1:0];
    c_n        = '0;
    c_n[0]     = seg_sum[0][SEG];
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_n[k]     = a_q[k-1];
      b_n[k]     = b_q[k-1];
      seg_sum[k] = {1'b0, a_n[k][k*SEG +: SEG]} + {1'b0, b_n[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_q[k-1]};
      r_n[k]     = r_q[k-1];
      r_n[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      c_n[k]     = seg_sum[k][SEG];
    end
    zero_n = (r_n[STAGES-1] == '0);
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    ovf_n  = a_n[STAGES-1][WIDTH-1] ^ b_n[STAGES-1][WIDTH-1]
           ^ r_n[STAGES-1][WIDTH-1] ^ c_n[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_n[k];
        b_q[k] <= b_n[k];
        r_q[k] <= r_n[k];
      end
      c_q    <= c_n;
      ovf_q  <= ovf_n;
      zero_q <= zero_n;
    end
  end

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: 16-bit/4-stage and 8-bit/1-stage instances, checked
// against an integer-arithmetic reference model plus directed literal vectors.
module tb_pipelined_rca;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, ir16, ov16, or16, cin16, sub16, fl16, co16, of16, zr16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, ov8, or8, cin8, sub8, fl8, co8, of8, zr8;
  logic [7:0]  a8, b8, s8;

  pipelined_rca #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .flush(fl16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16), .ovf(of16), .zero(zr16));

  pipelined_rca #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .flush(fl8), .out_valid(ov8), .out_ready(or8),
    .sum(s8), .cout(co8), .ovf(of8), .zero(zr8));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        of;
    logic        zr;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   accepted = 0;
  int   emitted = 0;
  exp_t q[$];
  exp_t e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical result.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic c, input logic s);
    longint m   = (longint'(1) << w);
    longint ua  = longint'(av) % m;
    longint ub  = longint'(bv) % m;
    longint ci  = longint'(c);
    longint half = m / 2;
    longint u, sa, sb, ideal;
    exp_t r;
    u  = s ? (ua - ub - ci + m) : (ua + ub + ci);
    sa = (ua >= half) ? ua - m : ua;
    sb = (ub >= half) ? ub - m : ub;
    ideal = s ? (sa - sb - ci) : (sa + sb + ci);
    r.s  = 16'(u % m);
    r.co = (u >= m);
    r.of = (ideal < -half) || (ideal >= half);
    r.zr = ((u % m) == 0);
    return r;
  endfunction

  // Scoreboard compare on the 16-bit instance, every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      check("in_ready rule", 32'(ir16), 32'(!(ov16 && !or16)));
      if (ov16) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected out_valid: got sum=%0h expected no result", s16);
        end else begin
          e = q[0];
          check("stream sum", 32'(s16), 32'(e.s));
          check("stream cout", 32'(co16), 32'(e.co));
          check("stream ovf", 32'(of16), 32'(e.of));
          check("stream zero", 32'(zr16), 32'(e.zr));
          if (or16 && !fl16) begin
            void'(q.pop_front());
            emitted++;
          end
        end
      end
      if (fl16) q.delete();
      else if (iv16 && ir16) begin
        q.push_back(model(16, a16, b16, cin16, sub16));
        accepted++;
      end
    end
  end

  task automatic drive(input int which, input logic [15:0] av, input logic [15:0] bv,
                       input logic c, input logic s, input logic v);
    if (which == 0) begin
      a16 = av; b16 = bv; cin16 = c; sub16 = s; iv16 = v;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = c; sub8 = s; iv8 = v;
    end
  endtask

  function automatic logic [19:0] outs(input int which);
    if (which == 0) return {ov16, co16, of16, zr16, s16};
    return {ov8, co8, of8, zr8, 8'h00, s8};
  endfunction

  task automatic run_one(input int which, input string nm, input logic [15:0] av,
                         input logic [15:0] bv, input logic c, input logic s,
                         input logic [15:0] esum, input logic eco, input logic eof,
                         input logic ezr);
    int n;
    int stages;
    logic [19:0] o;
    stages = (which == 0) ? 4 : 1;
    drive(which, av, bv, c, s, 1'b1);
    @(posedge clk);
    #1;
    drive(which, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      o = outs(which);
    end while (!o[19] && n < 20);
    check({nm, " latency"}, 32'(n), 32'(stages));
    check({nm, " sum"}, 32'(o[15:0]), 32'(esum));
    check({nm, " cout"}, 32'(o[18]), 32'(eco));
    check({nm, " ovf"}, 32'(o[17]), 32'(eof));
    check({nm, " zero"}, 32'(o[16]), 32'(ezr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic done;
    rst_n = 1'b0;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    or16 = 1'b1; or8 = 1'b1; fl16 = 1'b0; fl8 = 1'b0;
    #1;
    check("reset out_valid", 32'(ov16), 32'd0);
    check("reset in_ready", 32'(ir16), 32'd1);
    check("reset sum", 32'(s16), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    run_one(0, "t1 add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_one(0, "t2 ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one(0, "t2 ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one(0, "t3 sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one(0, "t3 subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_one(0, "t3 borrow", 16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Random stream with random backpressure.
    accepted = 0;
    emitted = 0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          drive(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
          n = 0;
          @(negedge clk);
          while (!ir16 && n < 100) begin
            @(negedge clk);
            n++;
          end
          if (n >= 100) check("stream accept timeout", 32'(n), 32'd0);
          @(posedge clk);
          #1;
        end
        drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          or16 = 1'($urandom_range(0, 1));
        end
        or16 = 1'b1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("stream drained", 32'(q.size()), 32'd0);
    check("stream accepted", 32'(accepted), 32'd20);
    check("stream emitted", 32'(emitted), 32'(accepted));

    // Flush with three in flight and a fourth presented on the flush edge.
    or16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    drive(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    fl16 = 1'b1;
    @(posedge clk);
    #1;
    fl16 = 1'b0;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("flush out_valid", 32'(ov16), 32'd0);
    end
    @(posedge clk);
    #1;
    run_one(0, "post-flush", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 0; i < 5; i++) begin
      drive(0, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    check("pre-reset out_valid", 32'(ov16), 32'd1);
    #2;
    rst_n = 1'b0;
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("async rst out_valid", 32'(ov16), 32'd0);
    check("async rst sum", 32'(s16), 32'd0);
    check("async rst flags", 32'({co16, of16, zr16}), 32'd0);
    check("async rst in_ready", 32'(ir16), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post-reset out_valid", 32'(ov16), 32'd0);
    end
    @(posedge clk);
    #1;

    // Degenerate single-stage 8-bit instance.
    run_one(1, "w8 ripple", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one(1, "w8 ovf", 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0);
    run_one(1, "w8 sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0);
    run_one(1, "w8 subovf", 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
